// File: rtl/sorter_v2_core.sv
// Streaming top-K MinHash sorter: keeps the K smallest signatures with their index tags.
// Optional SORTER_V2_DEDUP_EN drops inputs whose signature is already held.
module sorter_v2_core #(
    parameter int SIGNATURE_WIDTH = 32,
    parameter int INDEX_WIDTH     = 10,
    parameter int NUM_COMPARATORS = 8,
    parameter int LOG_COMPARATORS = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [SIGNATURE_WIDTH-1:0] signature_in,
    input  logic [INDEX_WIDTH-1:0]     index_in,
    output logic [INDEX_WIDTH-1:0]     indices_out [NUM_COMPARATORS-1:0]
);

    localparam int K  = NUM_COMPARATORS;
    localparam int PW = LOG_COMPARATORS + 1;

    typedef logic [SIGNATURE_WIDTH-1:0] sig_t;
    typedef logic [INDEX_WIDTH-1:0]     idx_t;

    logic [K-1:0] valid_q;
    logic [K-1:0] valid_d;
    sig_t         sig_q [K];
    sig_t         sig_d [K];
    idx_t         idx_q [K];
    idx_t         idx_d [K];

    logic [K-1:0]  le;
    logic [PW-1:0] pos;
    logic          dup;
    logic          hold;

    // Slots are sorted, so le is a thermometer and its popcount is the insert slot.
    always_comb begin
        le = '0;
        for (int i = 0; i < K; i++) begin
            le[i] = valid_q[i] && (sig_q[i] <= signature_in);
        end
    end

    always_comb begin
        pos = '0;
        for (int i = 0; i < K; i++) begin
            pos = pos + PW'(le[i]);
        end
    end

`ifdef SORTER_V2_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (valid_q[i] && (sig_q[i] == signature_in)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign hold = (pos == PW'(K)) || dup;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < K; i++) begin
            sig_d[i] = sig_q[i];
            idx_d[i] = idx_q[i];
            if (!hold && (PW'(i) == pos)) begin
                valid_d[i] = 1'b1;
                sig_d[i]   = signature_in;
                idx_d[i]   = index_in;
            end
        end
        for (int i = 1; i < K; i++) begin
            if (!hold && (PW'(i) > pos)) begin
                valid_d[i] = valid_q[i-1];
                sig_d[i]   = sig_q[i-1];
                idx_d[i]   = idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < K; i++) begin
                sig_q[i] <= '1;
                idx_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < K; i++) begin
                sig_q[i] <= sig_d[i];
                idx_q[i] <= idx_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            indices_out[i] = idx_q[i];
        end
    end

endmodule

// File: tb/tb_sorter_v2_core.sv
// Bench for sorter_v2_core: directed vector table, corner sequences, random stream vs history model.
// Define SORTER_V2_DEDUP_EN for both files to exercise the dedup build.
module tb_sorter_v2_core;

    typedef logic [7:0][9:0] outs_t;

    typedef struct {
        logic [31:0] sig;
        logic [9:0]  idx;
        outs_t       exp;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic [9:0]  x;
    } ent_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] signature_in;
    logic [9:0]  index_in;
    logic [9:0]  indices_out [7:0];

    int checks;
    int failures;

    ent_t hist[$];

    sorter_v2_core #(
        .SIGNATURE_WIDTH(32),
        .INDEX_WIDTH(10),
        .NUM_COMPARATORS(8),
        .LOG_COMPARATORS(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .signature_in(signature_in),
        .index_in(index_in),
        .indices_out(indices_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic outs_t mk(int e0, int e1, int e2, int e3,
                                 int e4, int e5, int e6, int e7);
        outs_t o;
        o[0] = 10'(e0); o[1] = 10'(e1); o[2] = 10'(e2); o[3] = 10'(e3);
        o[4] = 10'(e4); o[5] = 10'(e5); o[6] = 10'(e6); o[7] = 10'(e7);
        return o;
    endfunction

    task automatic check(input string name, input outs_t expv);
        outs_t act;
        for (int i = 0; i < 8; i++) act[i] = indices_out[i];
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic apply(input logic [31:0] s, input logic [9:0] x);
        signature_in = s;
        index_in     = x;
        @(posedge clock);
        #1;
    endtask

    // Reset asserted between edges, released before the next edge.
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Model: full history ordered by (signature, arrival); the DUT must
    // show the first eight entries of it.
    function automatic void model_push(input logic [31:0] s, input logic [9:0] x);
        int   p;
        bit   d;
        ent_t e;
        p = 0;
        d = 0;
        foreach (hist[j]) begin
            if (hist[j].s <= s) p++;
            if (hist[j].s == s) d = 1;
        end
`ifdef SORTER_V2_DEDUP_EN
        if (d) return;
`endif
        e.s = s;
        e.x = x;
        hist.insert(p, e);
    endfunction

    function automatic outs_t model_exp();
        outs_t o;
        for (int i = 0; i < 8; i++) o[i] = (i < hist.size()) ? hist[i].x : 10'd0;
        return o;
    endfunction

    vec_t vt [10];

    initial begin
        logic [31:0] rs;
        logic [9:0]  rx;
        int          r;

        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        signature_in = '1;
        index_in     = '0;
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));

        vt[0] = '{32'h10, 10'd1,  mk(1, 0, 0, 0, 0, 0, 0, 0)};
        vt[1] = '{32'h08, 10'd2,  mk(2, 1, 0, 0, 0, 0, 0, 0)};
        vt[2] = '{32'h20, 10'd3,  mk(2, 1, 3, 0, 0, 0, 0, 0)};
        vt[3] = '{32'h05, 10'd4,  mk(4, 2, 1, 3, 0, 0, 0, 0)};
        vt[4] = '{32'h15, 10'd5,  mk(4, 2, 1, 5, 3, 0, 0, 0)};
        vt[5] = '{32'h25, 10'd6,  mk(4, 2, 1, 5, 3, 6, 0, 0)};
        vt[6] = '{32'h35, 10'd7,  mk(4, 2, 1, 5, 3, 6, 7, 0)};
        vt[7] = '{32'h45, 10'd8,  mk(4, 2, 1, 5, 3, 6, 7, 8)};
        vt[8] = '{32'h55, 10'd9,  mk(4, 2, 1, 5, 3, 6, 7, 8)};
        vt[9] = '{32'h01, 10'd10, mk(10, 4, 2, 1, 5, 3, 6, 7)};

        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            apply(vt[k].sig, vt[k].idx);
            check($sformatf("table_%0d", k), vt[k].exp);
        end

        // Reset while full, observed without any clock edge.
        reset_n = 1'b0;
        #1;
        check("async_reset_full", mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        apply(32'hFFFF_FFFF, 10'd7);
        check("all_ones_after_reset", mk(7, 0, 0, 0, 0, 0, 0, 0));

        do_reset();
        apply(32'h30, 10'd1);
        check("single_insert", mk(1, 0, 0, 0, 0, 0, 0, 0));

        do_reset();
        apply(32'h40, 10'd1);
        apply(32'h40, 10'd2);
`ifdef SORTER_V2_DEDUP_EN
        check("tie_dedup", mk(1, 0, 0, 0, 0, 0, 0, 0));
`else
        check("tie_stable", mk(1, 2, 0, 0, 0, 0, 0, 0));
`endif
        apply(32'h40, 10'd3);
        apply(32'h3F, 10'd4);
`ifdef SORTER_V2_DEDUP_EN
        check("tie_then_smaller", mk(4, 1, 0, 0, 0, 0, 0, 0));
`else
        check("tie_then_smaller", mk(4, 1, 2, 3, 0, 0, 0, 0));
`endif

        do_reset();
        hist.delete();
        for (int n = 0; n < 1000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) rs = 32'($urandom_range(0, 63));
            else if (r < 9) rs = $urandom;
            else rs = '1;
            rx = 10'($urandom_range(1, 1023));
            apply(rs, rx);
            model_push(rs, rx);
            check($sformatf("random_%0d", n), model_exp());
            if (n == 500) begin
                reset_n = 1'b0;
                #1;
                hist.delete();
                check("random_midreset", model_exp());
                reset_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
